// File: rtl/kugelblitz_rx_capture.sv
// In-line RX AXI-stream monitor: zero-latency passthrough that snapshots 4 bytes at a
// programmable offset on each frame's first beat, read back through an AXI-lite slave.
module kugelblitz_rx_capture #(
    parameter int AXIS_DATA_WIDTH = 512,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int AXIS_USER_WIDTH = 81,
    parameter int AXIL_DATA_WIDTH = 32,
    parameter int AXIL_ADDR_WIDTH = 8,
    parameter int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    input  logic [AXIS_USER_WIDTH-1:0] s_axis_tuser,

    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [AXIS_USER_WIDTH-1:0] m_axis_tuser,

    input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]                 s_axil_awprot,
    input  logic                       s_axil_awvalid,
    output logic                       s_axil_awready,
    input  logic [AXIL_DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [AXIL_STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                       s_axil_wvalid,
    output logic                       s_axil_wready,
    output logic [1:0]                 s_axil_bresp,
    output logic                       s_axil_bvalid,
    input  logic                       s_axil_bready,
    input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]                 s_axil_arprot,
    input  logic                       s_axil_arvalid,
    output logic                       s_axil_arready,
    output logic [AXIL_DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]                 s_axil_rresp,
    output logic                       s_axil_rvalid,
    input  logic                       s_axil_rready
);

    localparam int AW = AXIL_ADDR_WIDTH - 2;
    localparam logic [AW-1:0] ADDR_CTRL   = AW'(0);
    localparam logic [AW-1:0] ADDR_STATUS = AW'(1);
    localparam logic [AW-1:0] ADDR_CAP    = AW'(2);
    localparam logic [AW-1:0] ADDR_FCOUNT = AW'(3);

    logic        ctrl_enable;
    logic [5:0]  ctrl_offset;
    logic        first_beat;
    logic        cap_valid;
    logic        cap_overflow;
    logic [31:0] cap_data;
    logic [31:0] frame_count;
    logic        bvalid_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [31:0] cap_word;
    logic [31:0] read_mux;
    logic [6:0]  byte_idx;
    logic [5:0]  wr_offset;

    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tkeep  = s_axis_tkeep;
    assign m_axis_tvalid = s_axis_tvalid;
    assign m_axis_tlast  = s_axis_tlast;
    assign m_axis_tuser  = s_axis_tuser;
    assign s_axis_tready = m_axis_tready;

    logic beat_fire, frame_end, capture;
    assign beat_fire = s_axis_tvalid & m_axis_tready;
    assign frame_end = beat_fire & s_axis_tlast;
    assign capture   = beat_fire & first_beat & ctrl_enable;

    logic wr_fire, rd_fire, wr_ctrl, wr_fcount, rd_cap;
    logic [AW-1:0] wr_word, rd_word;
    assign wr_word   = s_axil_awaddr[AXIL_ADDR_WIDTH-1:2];
    assign rd_word   = s_axil_araddr[AXIL_ADDR_WIDTH-1:2];
    assign wr_fire   = s_axil_awvalid & s_axil_wvalid & ~bvalid_q;
    assign rd_fire   = s_axil_arvalid & ~rvalid_q;
    assign wr_ctrl   = wr_fire & (wr_word == ADDR_CTRL);
    assign wr_fcount = wr_fire & (wr_word == ADDR_FCOUNT);
    assign rd_cap    = rd_fire & (rd_word == ADDR_CAP);

    assign s_axil_awready = wr_fire;
    assign s_axil_wready  = wr_fire;
    assign s_axil_arready = rd_fire;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_bresp   = 2'b00;
    assign s_axil_rresp   = 2'b00;

    assign wr_offset = (s_axil_wdata[13:8] > 6'd60) ? 6'd60 : s_axil_wdata[13:8];

    // Byte lanes beyond the end of the beat, or with tkeep low, contribute zero.
    always_comb begin
        cap_word = '0;
        byte_idx = '0;
        for (int j = 0; j < 4; j++) begin
            byte_idx = {1'b0, ctrl_offset} + 7'(j);
            if (!byte_idx[6] && s_axis_tkeep[byte_idx[5:0]])
                cap_word[8*j +: 8] = s_axis_tdata[{byte_idx[5:0], 3'b000} +: 8];
        end
    end

    always_comb begin
        read_mux = '0;
        case (rd_word)
            ADDR_CTRL:   read_mux = {18'b0, ctrl_offset, 7'b0, ctrl_enable};
            ADDR_STATUS: read_mux = {30'b0, cap_overflow, cap_valid};
            ADDR_CAP:    read_mux = cap_data;
            ADDR_FCOUNT: read_mux = frame_count;
            default:     read_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            first_beat <= 1'b1;
        else if (beat_fire)
            first_beat <= s_axis_tlast;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_enable <= 1'b0;
            ctrl_offset <= '0;
        end else if (wr_ctrl) begin
            if (s_axil_wstrb[0]) ctrl_enable <= s_axil_wdata[0];
            if (s_axil_wstrb[1]) ctrl_offset <= wr_offset;
        end
    end

    // A capture landing on the same edge as a CAP read wins cap_valid but drops overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_data     <= '0;
            cap_valid    <= 1'b0;
            cap_overflow <= 1'b0;
        end else if (capture) begin
            cap_data     <= cap_word;
            cap_valid    <= 1'b1;
            cap_overflow <= rd_cap ? 1'b0 : (cap_overflow | cap_valid);
        end else if (rd_cap) begin
            cap_valid    <= 1'b0;
            cap_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            frame_count <= '0;
        else if (wr_fcount)
            frame_count <= frame_end ? 32'd1 : 32'd0;
        else if (frame_end)
            frame_count <= frame_count + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (wr_fire)
                bvalid_q <= 1'b1;
            else if (s_axil_bready)
                bvalid_q <= 1'b0;
            if (rd_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= read_mux;
            end else if (s_axil_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[1:0], s_axil_araddr[1:0],
                             s_axil_wdata[AXIL_DATA_WIDTH-1:14], s_axil_wdata[7:1],
                             s_axil_wstrb[AXIL_STRB_WIDTH-1:2]};

endmodule
